fetch_redirect_ctrl: RTL and testbench

Controller that sequences the instruction-fetch PC, replacing the pass-through wiring between decode/execute redirect sources and the fetch stage. Each cycle it arbitrates between sequential fetch, decode-stage branch/jump, execute-stage JR, SIIC exception entry, RTI return and HALT. It then drives the next PC, the PC load enable and the IF/ID flush signals. It owns the EPC register and the run/exception/halt state.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 32 +++
 rtl/fetch_redirect_ctrl_if.sv | 35 +++
 rtl/fetch_redirect_ctrl_prio.sv | 53 +++++
 rtl/fetch_redirect_ctrl.sv | 76 +++++++
 tb/tb_fetch_redirect_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: run/exception/halt state
// and the one-hot-free select code produced by the priority selector.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_EXC,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_JR,
      SEL_HALT,
      SEL_SIIC,
      SEL_NEST,
      SEL_RTI,
      SEL_BR,
      SEL_HOLD
   } sel_e;

   localparam logic [15:0] EXC_VEC_DEFAULT = 16'h0002;

   function automatic logic sel_loads_pc(input sel_e sel);
      return !(sel inside {SEL_HOLD, SEL_HALT, SEL_NEST});
   endfunction

   function automatic logic sel_flushes_if(input sel_e sel);
      return sel inside {SEL_JR, SEL_SIIC, SEL_RTI, SEL_BR};
   endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect-source / fetch-control bundle between the pipeline and the
// fetch redirect controller.
interface fetch_redirect_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             stall;
   logic [WIDTH-1:0] pc_plus2;
   logic [WIDTH-1:0] pc_d;
   logic             br_take_d;
   logic [WIDTH-1:0] br_addr_d;
   logic             jr_take_x;
   logic [WIDTH-1:0] jr_addr_x;
   logic             siic_d;
   logic             rti_d;
   logic             halt_d;
   logic [WIDTH-1:0] next_pc;
   logic             pc_load;
   logic             flush_if;
   logic             flush_id;
   logic [WIDTH-1:0] epc;
   logic             in_exc;
   logic             halted;

   modport master (
      output stall, pc_plus2, pc_d, br_take_d, br_addr_d, jr_take_x, jr_addr_x,
             siic_d, rti_d, halt_d,
      input  next_pc, pc_load, flush_if, flush_id, epc, in_exc, halted
   );

   modport slave (
      input  stall, pc_plus2, pc_d, br_take_d, br_addr_d, jr_take_x, jr_addr_x,
             siic_d, rti_d, halt_d,
      output next_pc, pc_load, flush_if, flush_id, epc, in_exc, halted
   );
endinterface

// File: rtl/fetch_redirect_ctrl_prio.sv
// Combinational priority selector: picks the winning redirect source for this
// cycle (oldest instruction first) and muxes the corresponding next PC.
module fetch_redirect_prio
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH   = 16,
   parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VEC_DEFAULT)
) (
   input  state_e           state_i,
   input  logic             stall_i,
   input  logic [WIDTH-1:0] pc_plus2_i,
   input  logic [WIDTH-1:0] epc_i,
   input  logic             br_take_i,
   input  logic [WIDTH-1:0] br_addr_i,
   input  logic             jr_take_i,
   input  logic [WIDTH-1:0] jr_addr_i,
   input  logic             siic_i,
   input  logic             rti_i,
   input  logic             halt_i,
   output sel_e             sel_o,
   output logic [WIDTH-1:0] next_pc_o
);

   always_comb begin
      sel_o = SEL_SEQ;
      if (stall_i || state_i == ST_HALT) begin
         sel_o = SEL_HOLD;
      end else if (jr_take_i) begin
         // JR squashes the decode instruction, so decode events are dropped
         sel_o = SEL_JR;
      end else if (halt_i) begin
         sel_o = SEL_HALT;
      end else if (siic_i) begin
         sel_o = (state_i == ST_EXC) ? SEL_NEST : SEL_SIIC;
      end else if (rti_i) begin
         sel_o = SEL_RTI;
      end else if (br_take_i) begin
         sel_o = SEL_BR;
      end
   end

   always_comb begin
      next_pc_o = pc_plus2_i;
      case (sel_o)
         SEL_JR:   next_pc_o = jr_addr_i;
         SEL_SIIC: next_pc_o = EXC_VEC;
         SEL_RTI:  next_pc_o = epc_i;
         SEL_BR:   next_pc_o = br_addr_i;
         default:  next_pc_o = pc_plus2_i;
      endcase
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: owns run/exception/halt state and EPC, and drives the
// PC load enable, next PC and IF/ID flushes from the priority selector.
module fetch_redirect_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH   = 16,
   parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VEC_DEFAULT)
) (
   input logic                 clk,
   input logic                 rst,
   fetch_redirect_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             in_exc_q, halted_q;
   sel_e             sel;
   logic [WIDTH-1:0] prio_next_pc;

   fetch_redirect_prio #(
      .WIDTH   (WIDTH),
      .EXC_VEC (EXC_VEC)
   ) u_prio (
      .state_i    (state_q),
      .stall_i    (bus.stall),
      .pc_plus2_i (bus.pc_plus2),
      .epc_i      (epc_q),
      .br_take_i  (bus.br_take_d),
      .br_addr_i  (bus.br_addr_d),
      .jr_take_i  (bus.jr_take_x),
      .jr_addr_i  (bus.jr_addr_x),
      .siic_i     (bus.siic_d),
      .rti_i      (bus.rti_d),
      .halt_i     (bus.halt_d),
      .sel_o      (sel),
      .next_pc_o  (prio_next_pc)
   );

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      case (sel)
         SEL_HALT, SEL_NEST: state_d = ST_HALT;
         SEL_SIIC: begin
            state_d = ST_EXC;
            epc_d   = bus.pc_d + WIDTH'(2);
         end
         SEL_RTI:  state_d = ST_RUN;
         default:  state_d = state_q;
      endcase
   end

   // in_exc/halted are registered copies of the next state, not decoded from state_q
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         epc_q    <= '0;
         in_exc_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         in_exc_q <= (state_d == ST_EXC);
         halted_q <= (state_d == ST_HALT);
      end
   end

   assign bus.next_pc  = prio_next_pc;
   assign bus.pc_load  = sel_loads_pc(sel);
   assign bus.flush_if = sel_flushes_if(sel);
   assign bus.flush_id = (sel == SEL_JR);
   assign bus.epc      = epc_q;
   assign bus.in_exc   = in_exc_q;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scenarios plus randomized stimulus against a behavioural model of
// the fetch redirect controller.
module tb_fetch_redirect_ctrl;

   localparam int M_RUN  = 0;
   localparam int M_EXC  = 1;
   localparam int M_HALT = 2;
   localparam logic [15:0] VEC = 16'h0002;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   m_state;
   logic [15:0] m_epc;

   fetch_redirect_ctrl_if #(.WIDTH(16)) bus ();

   fetch_redirect_ctrl #(
      .WIDTH   (16),
      .EXC_VEC (VEC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall     = 1'b0;
      bus.pc_plus2  = 16'h0010;
      bus.pc_d      = 16'h000E;
      bus.br_take_d = 1'b0;
      bus.br_addr_d = 16'h0000;
      bus.jr_take_x = 1'b0;
      bus.jr_addr_x = 16'h0000;
      bus.siic_d    = 1'b0;
      bus.rti_d     = 1'b0;
      bus.halt_d    = 1'b0;
   endtask

   // Behavioural reference: outputs and successor state from the event rules
   function automatic void ref_model(
      input  int          st,
      input  logic [15:0] ep,
      output logic [15:0] npc,
      output logic        pl,
      output logic        fi,
      output logic        fd,
      output int          nst,
      output logic [15:0] nep
   );
      npc = bus.pc_plus2; pl = 1'b1; fi = 1'b0; fd = 1'b0; nst = st; nep = ep;
      if (st == M_HALT || bus.stall) begin
         pl = 1'b0;
      end else if (bus.jr_take_x) begin
         npc = bus.jr_addr_x; fi = 1'b1; fd = 1'b1;
      end else if (bus.halt_d) begin
         pl = 1'b0; nst = M_HALT;
      end else if (bus.siic_d && st == M_RUN) begin
         nep = 16'((32'(bus.pc_d) + 2) % 65536); npc = VEC; fi = 1'b1; nst = M_EXC;
      end else if (bus.siic_d) begin
         pl = 1'b0; nst = M_HALT;
      end else if (bus.rti_d) begin
         npc = ep; fi = 1'b1; nst = M_RUN;
      end else if (bus.br_take_d) begin
         npc = bus.br_addr_d; fi = 1'b1;
      end
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.pc_load !== 1'b1 || bus.halted !== 1'b0 || bus.in_exc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: pc_load=%b halted=%b in_exc=%b required 1 0 0", bus.pc_load, bus.halted, bus.in_exc);
      end
      rst = 1'b0;
      #3;
      n_checks++;
      if (bus.epc !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_epc: got %h required 0000", bus.epc);
      end
      n_checks++;
      if (bus.next_pc !== 16'h0010 || bus.pc_load !== 1'b1 || bus.flush_if !== 1'b0 || bus.flush_id !== 1'b0) begin
         n_fail++;
         $display("FAIL idle: next_pc=%h pc_load=%b fi=%b fd=%b required 0010 1 0 0", bus.next_pc, bus.pc_load, bus.flush_if, bus.flush_id);
      end
      tick();
      n_checks++;
      if (bus.halted !== 1'b0 || bus.in_exc !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_state: halted=%b in_exc=%b required 0 0", bus.halted, bus.in_exc);
      end
   endtask

   task automatic test_jr_priority();
      idle_inputs();
      bus.br_take_d = 1'b1; bus.br_addr_d = 16'h0040;
      bus.jr_take_x = 1'b1; bus.jr_addr_x = 16'h0100;
      bus.halt_d    = 1'b1;
      #3;
      n_checks++;
      if (bus.next_pc !== 16'h0100 || bus.pc_load !== 1'b1 || bus.flush_if !== 1'b1 || bus.flush_id !== 1'b1) begin
         n_fail++;
         $display("FAIL jr_prio: next_pc=%h pl=%b fi=%b fd=%b required 0100 1 1 1", bus.next_pc, bus.pc_load, bus.flush_if, bus.flush_id);
      end
      tick();
      idle_inputs();
      #3;
      n_checks++;
      if (bus.halted !== 1'b0) begin
         n_fail++;
         $display("FAIL jr_squash_halt: halted=%b required 0", bus.halted);
      end
      bus.br_take_d = 1'b1; bus.br_addr_d = 16'h0040;
      #1;
      n_checks++;
      if (bus.next_pc !== 16'h0040 || bus.flush_if !== 1'b1 || bus.flush_id !== 1'b0) begin
         n_fail++;
         $display("FAIL branch: next_pc=%h fi=%b fd=%b required 0040 1 0", bus.next_pc, bus.flush_if, bus.flush_id);
      end
      tick();
   endtask

   task automatic test_siic_rti();
      idle_inputs();
      bus.siic_d = 1'b1; bus.pc_d = 16'h0020; bus.br_take_d = 1'b1; bus.br_addr_d = 16'h0300;
      #3;
      n_checks++;
      if (bus.next_pc !== 16'h0002 || bus.pc_load !== 1'b1 || bus.flush_if !== 1'b1 || bus.flush_id !== 1'b0) begin
         n_fail++;
         $display("FAIL siic_entry: next_pc=%h pl=%b fi=%b fd=%b required 0002 1 1 0", bus.next_pc, bus.pc_load, bus.flush_if, bus.flush_id);
      end
      tick();
      idle_inputs();
      #3;
      n_checks++;
      if (bus.epc !== 16'h0022 || bus.in_exc !== 1'b1) begin
         n_fail++;
         $display("FAIL siic_state: epc=%h in_exc=%b required 0022 1", bus.epc, bus.in_exc);
      end
      tick();
      bus.rti_d = 1'b1;
      #3;
      n_checks++;
      if (bus.next_pc !== 16'h0022 || bus.flush_if !== 1'b1 || bus.pc_load !== 1'b1) begin
         n_fail++;
         $display("FAIL rti: next_pc=%h fi=%b pl=%b required 0022 1 1", bus.next_pc, bus.flush_if, bus.pc_load);
      end
      tick();
      idle_inputs();
      #3;
      n_checks++;
      if (bus.in_exc !== 1'b0) begin
         n_fail++;
         $display("FAIL rti_state: in_exc=%b required 0", bus.in_exc);
      end
      tick();
   endtask

   task automatic test_nested();
      idle_inputs();
      bus.siic_d = 1'b1; bus.pc_d = 16'h0020;
      tick();
      bus.pc_d = 16'h0080;
      #3;
      n_checks++;
      if (bus.pc_load !== 1'b0 || bus.flush_if !== 1'b0 || bus.flush_id !== 1'b0) begin
         n_fail++;
         $display("FAIL nested_outputs: pl=%b fi=%b fd=%b required 0 0 0", bus.pc_load, bus.flush_if, bus.flush_id);
      end
      tick();
      idle_inputs();
      #3;
      n_checks++;
      if (bus.halted !== 1'b1 || bus.in_exc !== 1'b0 || bus.epc !== 16'h0022) begin
         n_fail++;
         $display("FAIL nested_state: halted=%b in_exc=%b epc=%h required 1 0 0022", bus.halted, bus.in_exc, bus.epc);
      end
   endtask

   task automatic test_reset_in_halt();
      idle_inputs();
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.halted !== 1'b0 || bus.epc !== 16'h0000 || bus.pc_load !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_halt: halted=%b epc=%h pl=%b required 0 0000 1", bus.halted, bus.epc, bus.pc_load);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_halt_stall();
      idle_inputs();
      bus.halt_d = 1'b1; bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         n_checks++;
         if (bus.pc_load !== 1'b0 || bus.flush_if !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_stall[%0d]: pl=%b fi=%b halted=%b required 0 0 0", i, bus.pc_load, bus.flush_if, bus.halted);
         end
         tick();
      end
      bus.stall = 1'b0;
      #3;
      n_checks++;
      if (bus.pc_load !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_accept: pl=%b required 0", bus.pc_load);
      end
      tick();
      idle_inputs();
      bus.br_take_d = 1'b1; bus.br_addr_d = 16'h0500; bus.jr_take_x = 1'b1;
      #3;
      n_checks++;
      if (bus.halted !== 1'b1 || bus.pc_load !== 1'b0 || bus.flush_if !== 1'b0 || bus.flush_id !== 1'b0) begin
         n_fail++;
         $display("FAIL halted_ignores: halted=%b pl=%b fi=%b fd=%b required 1 0 0 0", bus.halted, bus.pc_load, bus.flush_if, bus.flush_id);
      end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] e_npc, e_nep;
      logic        e_pl, e_fi, e_fd;
      int          e_nst;
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_state = M_RUN;
      m_epc   = 16'h0000;
      for (int c = 0; c < 2000; c++) begin
         rst           = ($urandom_range(99) < 3);
         bus.stall     = ($urandom_range(99) < 20);
         bus.pc_plus2  = 16'($urandom);
         bus.pc_d      = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom);
         bus.jr_take_x = ($urandom_range(99) < 15);
         bus.jr_addr_x = 16'($urandom);
         bus.br_take_d = ($urandom_range(99) < 30);
         bus.br_addr_d = 16'($urandom);
         bus.siic_d    = ($urandom_range(99) < 12);
         bus.rti_d     = ($urandom_range(99) < 12);
         bus.halt_d    = ($urandom_range(99) < 3);
         if (rst) begin
            m_state = M_RUN;
            m_epc   = 16'h0000;
         end
         #3;
         ref_model(m_state, m_epc, e_npc, e_pl, e_fi, e_fd, e_nst, e_nep);
         n_checks++;
         if (bus.pc_load !== e_pl || bus.flush_if !== e_fi || bus.flush_id !== e_fd) begin
            n_fail++;
            $display("FAIL rand_ctrl[%0d]: pl=%b fi=%b fd=%b required %b %b %b", c, bus.pc_load, bus.flush_if, bus.flush_id, e_pl, e_fi, e_fd);
         end
         if (e_pl) begin
            n_checks++;
            if (bus.next_pc !== e_npc) begin
               n_fail++;
               $display("FAIL rand_next_pc[%0d]: got %h required %h", c, bus.next_pc, e_npc);
            end
         end
         n_checks++;
         if (bus.epc !== m_epc || bus.in_exc !== (m_state == M_EXC) || bus.halted !== (m_state == M_HALT)) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: epc=%h in_exc=%b halted=%b required %h %b %b", c, bus.epc, bus.in_exc, bus.halted,
                     m_epc, (m_state == M_EXC), (m_state == M_HALT));
         end
         @(posedge clk);
         if (!rst) begin
            m_state = e_nst;
            m_epc   = e_nep;
         end
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_jr_priority();
      test_siic_rti();
      test_nested();
      test_reset_in_halt();
      test_halt_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
